// File: rtl/axi_arb_pkg.sv
// Shared types, constants and helpers for the AXI4-Lite weighted round-robin arbiter.
package axi_arb_pkg;

    localparam int unsigned DEFAULT_WEIGHT_WIDTH = 4;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 64;

    typedef logic [DEFAULT_WEIGHT_WIDTH-1:0] weight_t;
    typedef logic [DEFAULT_WEIGHT_WIDTH-1:0] credit_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned arb_idx_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_find_first.sv
// Rotated priority search: first set bit of req_vec starting at start_idx, wrapping modulo NUM_REQ.
module rr_find_first
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = arb_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   start_idx,
    output logic               found,
    output logic [IDX_W-1:0]   found_idx
);

    localparam logic [IDX_W:0] NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDX_W:0]       off_s;
    logic [IDX_W:0]       sum_s;
    logic [IDX_W:0]       wrap_s;

    // Rotate so bit 0 is the start position, pick the lowest set offset, then map back
    always_comb begin
        dbl_s = {req_vec, req_vec} >> start_idx;
        rot_s = dbl_s[NUM_REQ-1:0];
        found = 1'b0;
        off_s = {(IDX_W+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            found = found | rot_s[k];
            off_s = rot_s[k] ? (IDX_W+1)'(k) : off_s;
        end
        sum_s  = {1'b0, start_idx} + off_s;
        wrap_s = sum_s - NUM_REQ_EXT;
        if (sum_s >= NUM_REQ_EXT) begin
            found_idx = wrap_s[IDX_W-1:0];
        end else begin
            found_idx = sum_s[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/axi_lite_wrr_arbiter.sv
// Weighted round-robin arbiter for one AXI4-Lite crossbar channel (AR or AW).
// Optional starvation guard is enabled by defining AXI_LITE_ARB_STARVE_GUARD_EN.
module axi_lite_wrr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    localparam int unsigned IDX_W       = arb_idx_w(NUM_REQ)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              in_req_i,
    input  logic [NUM_REQ*WEIGHT_WIDTH-1:0] weight_i,
    output logic                            out_req_o,
    output logic [IDX_W-1:0]                out_sel_o,
    input  logic                            out_ack_i,
    output logic                            starved_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]        ptr_r;
    logic [WEIGHT_WIDTH-1:0] credit_r;
    logic [WEIGHT_WIDTH-1:0] weight_arr_s [NUM_REQ];
    logic [IDX_W-1:0]        start_s;
    logic [IDX_W-1:0]        rr_idx_s;
    logic [IDX_W-1:0]        rr_sel_s;
    logic [IDX_W-1:0]        sel_s;
    logic                    rr_found_s;
    logic                    burst_s;
    logic                    fire_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_weight
        assign weight_arr_s[g] = weight_i[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    // Search begins just after the last winner so the last winner is considered last
    always_comb begin
        if (ptr_r == LAST_IDX) begin
            start_s = {IDX_W{1'b0}};
        end else begin
            start_s = ptr_r + IDX_W'(1);
        end
    end

    rr_find_first #(.NUM_REQ(NUM_REQ)) u_rr_search (
        .req_vec   (in_req_i),
        .start_idx (start_s),
        .found     (rr_found_s),
        .found_idx (rr_idx_s)
    );

    // A live burst keeps the current owner; otherwise rotate, falling back to ptr when idle
    always_comb begin
        burst_s  = in_req_i[ptr_r] && (credit_r != {WEIGHT_WIDTH{1'b0}});
        rr_sel_s = ptr_r;
        if (burst_s) begin
            rr_sel_s = ptr_r;
        end else if (rr_found_s) begin
            rr_sel_s = rr_idx_s;
        end else begin
            rr_sel_s = ptr_r;
        end
    end

`ifdef AXI_LITE_ARB_STARVE_GUARD_EN
    localparam int unsigned       CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]   wait_r [NUM_REQ];
    logic [NUM_REQ-1:0] starving_s;
    logic               starve_found_s;
    logic [IDX_W-1:0]   starve_idx_s;

    // Masters that have waited the full limit and are still requesting
    always_comb begin
        starving_s = {NUM_REQ{1'b0}};
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            starving_s[i] = in_req_i[i] && (wait_r[i] == LIMIT_CNT);
        end
    end

    rr_find_first #(.NUM_REQ(NUM_REQ)) u_starve_search (
        .req_vec   (starving_s),
        .start_idx ({IDX_W{1'b0}}),
        .found     (starve_found_s),
        .found_idx (starve_idx_s)
    );

    assign sel_s     = starve_found_s ? starve_idx_s : rr_sel_s;
    assign starved_o = starve_found_s;

    // Saturating wait counters; cleared when the master is served or stops asking
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rst_i) begin
                wait_r[i] <= {CNT_W{1'b0}};
            end else if (!in_req_i[i] || (fire_s && (sel_s == IDX_W'(i)))) begin
                wait_r[i] <= {CNT_W{1'b0}};
            end else if (wait_r[i] != LIMIT_CNT) begin
                wait_r[i] <= wait_r[i] + CNT_W'(1);
            end else begin
                wait_r[i] <= wait_r[i];
            end
        end
    end
`else
    assign sel_s     = rr_sel_s;
    assign starved_o = 1'b0;
`endif

    assign out_req_o = |in_req_i;
    assign out_sel_o = sel_s;
    assign fire_s    = out_ack_i && out_req_o;

    // Grant bookkeeping: spend credit inside a burst, otherwise move ptr and reload credit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r    <= LAST_IDX;
            credit_r <= {WEIGHT_WIDTH{1'b0}};
        end else if (fire_s) begin
            if ((sel_s == ptr_r) && (credit_r != {WEIGHT_WIDTH{1'b0}})) begin
                ptr_r    <= ptr_r;
                credit_r <= credit_r - WEIGHT_WIDTH'(1);
            end else begin
                ptr_r    <= sel_s;
                credit_r <= weight_arr_s[sel_s];
            end
        end else begin
            ptr_r    <= ptr_r;
            credit_r <= credit_r;
        end
    end

endmodule

// File: tb/tb_axi_lite_wrr_arbiter.sv
// Scoreboard bench for axi_lite_wrr_arbiter: directed sequences plus randomized traffic
// against a queue-fed reference model; a NUM_REQ=3 instance covers non-power-of-two wrap.
module tb_axi_lite_wrr_arbiter;

    localparam int N   = 4;
    localparam int WW  = 4;
    localparam int LIM = 8;

    typedef struct {
        int req;
        int sel;
        int stv;
        int tid;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst  = 1'b1;
    logic            ack  = 1'b0;
    logic [N-1:0]    req  = '0;
    logic [N*WW-1:0] wvec = '0;
    logic            oreq;
    logic [1:0]      osel;
    logic            ostv;

    logic            rst3  = 1'b1;
    logic            ack3  = 1'b0;
    logic [2:0]      req3  = '0;
    logic [11:0]     wvec3 = '0;
    logic            oreq3;
    logic [1:0]      osel3;
    logic            ostv3;

    axi_lite_wrr_arbiter #(.NUM_REQ(N), .WEIGHT_WIDTH(WW), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst), .in_req_i(req), .weight_i(wvec),
        .out_req_o(oreq), .out_sel_o(osel), .out_ack_i(ack), .starved_o(ostv)
    );

    axi_lite_wrr_arbiter #(.NUM_REQ(3), .WEIGHT_WIDTH(4)) dut3 (
        .clk_i(clk), .rst_i(rst3), .in_req_i(req3), .weight_i(wvec3),
        .out_req_o(oreq3), .out_sel_o(osel3), .out_ack_i(ack3), .starved_o(ostv3)
    );

    exp_t q4[$];
    exp_t q3[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model state for the 4-master instance
    int w[N];
    int m_ptr    = 0;
    int m_credit = 0;
    int m_wait[N];
    bit m_valid  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop one expectation per cycle per instance and compare
    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            checks++;
            if ({oreq, osel, ostv} !== {1'(e.req), 2'(e.sel), 1'(e.stv)}) begin
                failures++;
                $display("FAIL arb4 test%0d cyc%0d: req/sel/starved got %b/%0d/%b want %0d/%0d/%0d",
                         e.tid, cyc, oreq, osel, ostv, e.req, e.sel, e.stv);
            end
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            checks++;
            if ({oreq3, osel3, ostv3} !== {1'(e.req), 2'(e.sel), 1'(e.stv)}) begin
                failures++;
                $display("FAIL arb3 test%0d cyc%0d: req/sel/starved got %b/%0d/%b want %0d/%0d/%0d",
                         e.tid, cyc, oreq3, osel3, ostv3, e.req, e.sel, e.stv);
            end
        end
    end

    function automatic logic [N*WW-1:0] pack_w();
        logic [N*WW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WW +: WW] = WW'(w[i]);
        return v;
    endfunction

    // Who should be offered: continuing burst, else next requester after ptr, ptr last
    function automatic void model_out(input logic [N-1:0] r, output int mreq, output int msel,
                                      output int mstv);
        bit done;
        mreq = (r != '0) ? 1 : 0;
        msel = m_ptr;
        mstv = 0;
        done = (r[m_ptr] && m_credit > 0);
        for (int k = 1; k <= N; k++) begin
            if (!done && r[(m_ptr + k) % N]) begin
                msel = (m_ptr + k) % N;
                done = 1'b1;
            end
        end
`ifdef AXI_LITE_ARB_STARVE_GUARD_EN
        done = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!done && r[i] && m_wait[i] >= LIM) begin
                msel = i;
                mstv = 1;
                done = 1'b1;
            end
        end
`endif
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic a, input logic rs,
                                       input int mreq, input int msel);
        bit granted;
        granted = a && (mreq != 0);
        if (rs) begin
            m_ptr    = N - 1;
            m_credit = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            m_valid  = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!r[i] || (granted && msel == i)) m_wait[i] = 0;
                else if (m_wait[i] < LIM)            m_wait[i] = m_wait[i] + 1;
            end
            if (granted) begin
                if (msel == m_ptr && m_credit > 0) begin
                    m_credit = m_credit - 1;
                end else begin
                    m_ptr    = msel;
                    m_credit = w[msel];
                end
            end
        end
    endfunction

    // Drive one cycle; esel>=0 pins a hand-derived expectation, else the model's is used
    task automatic step4(input logic [N-1:0] r, input logic a, input logic rs,
                         input int esel, input int estv, input int tid);
        int mreq, msel, mstv;
        exp_t e;
        req  = r;
        ack  = a;
        rst  = rs;
        wvec = pack_w();
        model_out(r, mreq, msel, mstv);
        if (m_valid) begin
            e.req = mreq;
            e.sel = (esel >= 0) ? esel : msel;
            e.stv = (esel >= 0) ? estv : mstv;
            e.tid = tid;
            q4.push_back(e);
        end
        model_step(r, a, rs, mreq, msel);
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic [2:0] r, input logic a, input logic rs, input int esel,
                         input int tid);
        exp_t e;
        req3 = r;
        ack3 = a;
        rst3 = rs;
        if (esel >= 0) begin
            e.req = (r != '0) ? 1 : 0;
            e.sel = esel;
            e.stv = 0;
            e.tid = tid;
            q3.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset4();
        step4('0, 1'b0, 1'b1, -1, 0, 0);
    endtask

    task automatic run4();
        logic [N-1:0] rr;
        int seq3[8];
        // 1: pure round robin, reset state first
        for (int i = 0; i < N; i++) w[i] = 0;
        reset4();
        step4(4'b0000, 1'b0, 1'b0, 3, 0, 1);
        for (int i = 0; i < 5; i++) step4(4'b1111, 1'b1, 1'b0, i % 4, 0, 1);
        // 2: weight 2 on master 0 gives three back-to-back grants
        w[0] = 2;
        reset4();
        for (int i = 0; i < 8; i++) step4(4'b0011, 1'b1, 1'b0, (i % 4 == 3) ? 1 : 0, 0, 2);
        // 3: dropping a request forfeits credit; re-asserting earns a fresh burst
        w[0] = 3;
        reset4();
        seq3 = '{0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) step4((i == 2) ? 4'b0010 : 4'b0011, 1'b1, 1'b0, seq3[i], 0, 3);
        // 4: held offer without ack, stray ack while idle, then the loaded burst
        for (int i = 0; i < N; i++) w[i] = 0;
        w[2] = 5;
        reset4();
        for (int i = 0; i < 5; i++) step4(4'b0100, 1'b0, 1'b0, 2, 0, 4);
        step4(4'b0100, 1'b1, 1'b0, 2, 0, 4);
        step4(4'b0000, 1'b1, 1'b0, 2, 0, 4);
        for (int i = 0; i < 6; i++) step4(4'b0110, 1'b1, 1'b0, (i == 5) ? 1 : 2, 0, 4);
        // 5: heavy weight on master 1 against master 0
        for (int i = 0; i < N; i++) w[i] = 0;
        w[1] = 15;
        reset4();
        for (int i = 0; i < 18; i++) begin
`ifdef AXI_LITE_ARB_STARVE_GUARD_EN
            step4(4'b0011, 1'b1, 1'b0, (i == 0 || i == 9) ? 0 : 1, (i == 9) ? 1 : 0, 5);
`else
            step4(4'b0011, 1'b1, 1'b0, (i == 0 || i == 17) ? 0 : 1, 0, 5);
`endif
        end
        // 6: randomized traffic with sticky requests, weight changes and occasional resets
        rr = 4'b0101;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                for (int i = 0; i < N; i++)
                    w[i] = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
            end
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) rr[i] = ~rr[i];
            step4(rr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0), -1, 0, 6);
        end
    endtask

    task automatic run3();
        wvec3 = '0;
        step3(3'b000, 1'b0, 1'b1, -1, 7);
        step3(3'b000, 1'b0, 1'b0, 2, 7);
        for (int i = 0; i < 4; i++) step3(3'b101, 1'b1, 1'b0, (i % 2 == 0) ? 0 : 2, 7);
        wvec3[8 +: 4] = 4'd3;
        step3(3'b101, 1'b1, 1'b0, 0, 8);
        step3(3'b101, 1'b1, 1'b0, 2, 8);
        step3(3'b101, 1'b0, 1'b1, 2, 8);
        step3(3'b101, 1'b1, 1'b0, 0, 8);
        step3(3'b101, 1'b1, 1'b0, 2, 8);
        step3(3'b101, 1'b1, 1'b0, 2, 8);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            w[i]      = 0;
            m_wait[i] = 0;
        end
        @(posedge clk);
        #1;
        fork
            run4();
            run3();
        join
        @(posedge clk);
        @(negedge clk);
        #1;
        if (q4.size() != 0 || q3.size() != 0) begin
            failures++;
            $display("FAIL drain: pending expectations got %0d/%0d want 0/0", q4.size(), q3.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
